lvc_ahb_bus_checker: RTL and testbench



---
 rtl/lvc_ahb_bus_checker.sv | 245 ++++++++++++++++++++++++
 tb/tb_lvc_ahb_bus_checker.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvc_ahb_bus_checker.sv
// Passive AHB segment observer: rebuilds completed transfers into one-cycle records,
// flags protocol violations with a coded pulse and keeps saturating counters.
module lvc_ahb_bus_checker #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16,
   parameter int MAX_WAIT   = 16
) (
   input  logic                  hclk,
   input  logic                  hresetn,
   input  logic [ADDR_WIDTH-1:0] haddr,
   input  logic [1:0]            htrans,
   input  logic [2:0]            hburst,
   input  logic [2:0]            hsize,
   input  logic                  hwrite,
   input  logic [DATA_WIDTH-1:0] hwdata,
   input  logic [DATA_WIDTH-1:0] hrdata,
   input  logic                  hready,
   input  logic [1:0]            hresp,
   input  logic                  clr,
   output logic                  xfer_valid,
   output logic [ADDR_WIDTH-1:0] xfer_addr,
   output logic                  xfer_write,
   output logic [2:0]            xfer_size,
   output logic [DATA_WIDTH-1:0] xfer_data,
   output logic [1:0]            xfer_resp,
   output logic                  err_valid,
   output logic [2:0]            err_code,
   output logic [CNT_WIDTH-1:0]  xfer_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt
);

   localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);
   localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_BUSY   = 2'd1;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;
   localparam logic [1:0] RESP_OKAY = 2'd0;
   localparam logic [2:0] BURST_SINGLE = 3'd0;

   typedef enum logic [1:0] {DP_IDLE, DP_ACTIVE, DP_RESP2} dp_state_t;
   typedef enum logic {BURST_IDLE, BURST_ACT} burst_state_t;

   dp_state_t              r_dp_state;
   logic [ADDR_WIDTH-1:0]  r_dp_addr;
   logic                   r_dp_write;
   logic [2:0]             r_dp_size;

   burst_state_t           r_burst_state;
   logic [ADDR_WIDTH-1:0]  r_b_addr;
   logic [2:0]             r_b_size;
   logic [2:0]             r_b_burst;

   logic [WAIT_W-1:0]      r_wait_cnt;

   logic                   r_prev_hready;
   logic [1:0]             r_prev_htrans;
   logic [ADDR_WIDTH-1:0]  r_prev_haddr;
   logic                   r_prev_hwrite;
   logic [2:0]             r_prev_hsize;
   logic [1:0]             r_prev_hresp;

   logic                   r_xfer_valid;
   logic [ADDR_WIDTH-1:0]  r_xfer_addr;
   logic                   r_xfer_write;
   logic [2:0]             r_xfer_size;
   logic [DATA_WIDTH-1:0]  r_xfer_data;
   logic [1:0]             r_xfer_resp;
   logic                   r_err_valid;
   logic [2:0]             r_err_code;
   logic [CNT_WIDTH-1:0]   r_xfer_cnt;
   logic [CNT_WIDTH-1:0]   r_err_cnt;

   logic                   w_accept;
   logic                   w_dp_busy;
   logic                   w_complete;
   logic                   w_stall;
   logic [ADDR_WIDTH-1:0]  w_seq_expect;
   logic [ADDR_WIDTH-1:0]  w_align_mask;
   logic                   w_ctrl_changed;
   logic                   w_err_abort;
   logic [7:1]             w_viol;
   logic [2:0]             w_code;

   assign w_accept     = hready & htrans[1];
   assign w_dp_busy    = (r_dp_state != DP_IDLE);
   assign w_complete   = w_dp_busy & hready;
   assign w_stall      = w_dp_busy & ~hready;
   assign w_seq_expect = r_b_addr + (ADDR_WIDTH'(1) << r_b_size);
   assign w_align_mask = (ADDR_WIDTH'(1) << hsize) - ADDR_WIDTH'(1);

   assign w_ctrl_changed = (haddr != r_prev_haddr) | (htrans != r_prev_htrans) |
                           (hwrite != r_prev_hwrite) | (hsize != r_prev_hsize);
   // A master may drop a stalled NONSEQ to IDLE once the slave signals a two-cycle error.
   assign w_err_abort = (r_prev_htrans == TR_NONSEQ) & (htrans == TR_IDLE) &
                        (r_prev_hresp != RESP_OKAY);

   assign w_viol[1] = hready & ((htrans == TR_SEQ) | (htrans == TR_BUSY)) &
                      (r_burst_state == BURST_IDLE);
   assign w_viol[2] = w_accept & (htrans == TR_SEQ) & (r_burst_state == BURST_ACT) &
                      r_b_burst[0] & (haddr != w_seq_expect);
   assign w_viol[3] = ~r_prev_hready & r_prev_htrans[1] & w_ctrl_changed & ~w_err_abort;
   assign w_viol[4] = hready & (hresp != RESP_OKAY) &
                      ~(~r_prev_hready & (r_prev_hresp == hresp));
   assign w_viol[5] = w_stall & (r_wait_cnt == WAIT_W'(MAX_WAIT - 1));
   assign w_viol[6] = w_accept & (int'(hsize) > MAX_SIZE);
   assign w_viol[7] = w_accept & (|(haddr & w_align_mask));

   always_comb begin
      w_code = 3'd0;
      for (int i = 7; i >= 1; i--) begin
         if (w_viol[i]) w_code = 3'(i);
      end
   end

   // Data-phase tracking and completed-transfer record.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_dp_state   <= DP_IDLE;
         r_dp_addr    <= '0;
         r_dp_write   <= 1'b0;
         r_dp_size    <= 3'd0;
         r_xfer_valid <= 1'b0;
         r_xfer_addr  <= '0;
         r_xfer_write <= 1'b0;
         r_xfer_size  <= 3'd0;
         r_xfer_data  <= '0;
         r_xfer_resp  <= 2'd0;
      end else begin
         unique case (r_dp_state)
            DP_IDLE: begin
               if (w_accept) r_dp_state <= DP_ACTIVE;
            end
            DP_ACTIVE: begin
               if (hready)                  r_dp_state <= w_accept ? DP_ACTIVE : DP_IDLE;
               else if (hresp != RESP_OKAY) r_dp_state <= DP_RESP2;
            end
            DP_RESP2: begin
               if (hready) r_dp_state <= w_accept ? DP_ACTIVE : DP_IDLE;
            end
            default: r_dp_state <= DP_IDLE;
         endcase
         if (w_accept) begin
            r_dp_addr  <= haddr;
            r_dp_write <= hwrite;
            r_dp_size  <= hsize;
         end
         r_xfer_valid <= w_complete;
         if (w_complete) begin
            r_xfer_addr  <= r_dp_addr;
            r_xfer_write <= r_dp_write;
            r_xfer_size  <= r_dp_size;
            r_xfer_data  <= r_dp_write ? hwdata : hrdata;
            r_xfer_resp  <= hresp;
         end
      end
   end

   // Burst tracking; only sampled address phases (hready=1) move it.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_burst_state <= BURST_IDLE;
         r_b_addr      <= '0;
         r_b_size      <= 3'd0;
         r_b_burst     <= 3'd0;
      end else if (hready) begin
         unique case (htrans)
            TR_IDLE: r_burst_state <= BURST_IDLE;
            TR_BUSY: r_burst_state <= r_burst_state;
            TR_NONSEQ: begin
               r_b_addr  <= haddr;
               r_b_size  <= hsize;
               r_b_burst <= hburst;
               r_burst_state <= (hburst == BURST_SINGLE) ? BURST_IDLE : BURST_ACT;
            end
            TR_SEQ: begin
               if (r_burst_state == BURST_ACT) r_b_addr <= haddr;
            end
            default: r_burst_state <= BURST_IDLE;
         endcase
      end
   end

   // Consecutive stall counter; sticking at MAX_WAIT makes the timeout fire once per stall.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_wait_cnt <= '0;
      end else if (w_stall) begin
         if (r_wait_cnt != WAIT_W'(MAX_WAIT)) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end else begin
         r_wait_cnt <= '0;
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_prev_hready <= 1'b0;
         r_prev_htrans <= 2'd0;
         r_prev_haddr  <= '0;
         r_prev_hwrite <= 1'b0;
         r_prev_hsize  <= 3'd0;
         r_prev_hresp  <= 2'd0;
      end else begin
         r_prev_hready <= hready;
         r_prev_htrans <= htrans;
         r_prev_haddr  <= haddr;
         r_prev_hwrite <= hwrite;
         r_prev_hsize  <= hsize;
         r_prev_hresp  <= hresp;
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_err_valid <= 1'b0;
         r_err_code  <= 3'd0;
         r_xfer_cnt  <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_err_valid <= |w_viol;
         if (|w_viol) r_err_code <= w_code;
         if (clr) begin
            r_xfer_cnt <= '0;
            r_err_cnt  <= '0;
         end else begin
            if (w_complete && !(&r_xfer_cnt)) r_xfer_cnt <= r_xfer_cnt + CNT_WIDTH'(1);
            if ((|w_viol) && !(&r_err_cnt))   r_err_cnt  <= r_err_cnt + CNT_WIDTH'(1);
         end
      end
   end

   assign xfer_valid = r_xfer_valid;
   assign xfer_addr  = r_xfer_addr;
   assign xfer_write = r_xfer_write;
   assign xfer_size  = r_xfer_size;
   assign xfer_data  = r_xfer_data;
   assign xfer_resp  = r_xfer_resp;
   assign err_valid  = r_err_valid;
   assign err_code   = r_err_code;
   assign xfer_cnt   = r_xfer_cnt;
   assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_lvc_ahb_bus_checker.sv
// Randomized bench for lvc_ahb_bus_checker with a transfer-level reference model.
module tb_lvc_ahb_bus_checker;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int CW = 4;
   localparam int MW = 16;
   localparam int CNT_MAX = (1 << CW) - 1;

   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;

   logic          hclk = 1'b0;
   logic          hresetn;
   logic [AW-1:0] haddr;
   logic [1:0]    htrans;
   logic [2:0]    hburst;
   logic [2:0]    hsize;
   logic          hwrite;
   logic [DW-1:0] hwdata;
   logic [DW-1:0] hrdata;
   logic          hready;
   logic [1:0]    hresp;
   logic          clr;
   logic          xfer_valid;
   logic [AW-1:0] xfer_addr;
   logic          xfer_write;
   logic [2:0]    xfer_size;
   logic [DW-1:0] xfer_data;
   logic [1:0]    xfer_resp;
   logic          err_valid;
   logic [2:0]    err_code;
   logic [CW-1:0] xfer_cnt;
   logic [CW-1:0] err_cnt;

   always #5 hclk = ~hclk;

   lvc_ahb_bus_checker #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW), .MAX_WAIT(MW)
   ) u_dut (
      .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans), .hburst(hburst),
      .hsize(hsize), .hwrite(hwrite), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
      .hresp(hresp), .clr(clr), .xfer_valid(xfer_valid), .xfer_addr(xfer_addr),
      .xfer_write(xfer_write), .xfer_size(xfer_size), .xfer_data(xfer_data),
      .xfer_resp(xfer_resp), .err_valid(err_valid), .err_code(err_code),
      .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: one outstanding transfer, burst bookkeeping, stall length, last cycle.
   bit            m_pend;
   logic [AW-1:0] m_pend_addr;
   bit            m_pend_write;
   int            m_pend_size;
   int            m_stall;
   bit            m_in_burst;
   int            m_b_burst;
   logic [AW-1:0] m_b_addr;
   int            m_b_size;
   bit            p_ready;
   logic [1:0]    p_trans;
   logic [AW-1:0] p_addr;
   bit            p_write;
   logic [2:0]    p_size;
   logic [1:0]    p_resp;

   bit            e_xv;
   logic [AW-1:0] e_addr;
   bit            e_write;
   int            e_size;
   logic [DW-1:0] e_data;
   int            e_resp;
   bit            e_ev;
   int            e_code;
   int            e_xcnt;
   int            e_ecnt;

   task automatic model_reset();
      m_pend = 0; m_pend_addr = '0; m_pend_write = 0; m_pend_size = 0;
      m_stall = 0; m_in_burst = 0; m_b_burst = 0; m_b_addr = '0; m_b_size = 0;
      p_ready = 0; p_trans = IDLE; p_addr = '0; p_write = 0; p_size = 0; p_resp = 0;
      e_xv = 0; e_addr = '0; e_write = 0; e_size = 0; e_data = '0; e_resp = 0;
      e_ev = 0; e_code = 0; e_xcnt = 0; e_ecnt = 0;
   endtask

   // Evaluate the current bus cycle: predicts DUT outputs after the coming edge.
   task automatic model_step();
      bit accept, complete, any;
      bit flag [1:7];
      int code;
      if (!hresetn) begin
         model_reset();
         return;
      end
      accept   = hready && (htrans == NONSEQ || htrans == SEQ);
      complete = m_pend && hready;
      e_xv = complete;
      if (complete) begin
         e_addr  = m_pend_addr;
         e_write = m_pend_write;
         e_size  = m_pend_size;
         e_data  = m_pend_write ? hwdata : hrdata;
         e_resp  = hresp;
      end
      flag[1] = hready && (htrans == SEQ || htrans == BUSY) && !m_in_burst;
      flag[2] = accept && htrans == SEQ && m_in_burst && (m_b_burst % 2 == 1) &&
                haddr != m_b_addr + (32'd1 << m_b_size);
      flag[3] = !p_ready && (p_trans == NONSEQ || p_trans == SEQ) &&
                (haddr != p_addr || htrans != p_trans || hwrite != p_write || hsize != p_size) &&
                !(p_trans == NONSEQ && htrans == IDLE && p_resp != 0);
      flag[4] = hready && hresp != 0 && !(!p_ready && p_resp == hresp);
      flag[5] = m_pend && !hready && (m_stall + 1 == MW);
      flag[6] = accept && (32'd1 << hsize) > DW / 8;
      flag[7] = accept && (haddr % (32'd1 << hsize)) != 0;
      code = 0;
      for (int c = 7; c >= 1; c--) if (flag[c]) code = c;
      any  = (code != 0);
      e_ev = any;
      if (any) e_code = code;
      if (clr) begin
         e_xcnt = 0;
         e_ecnt = 0;
      end else begin
         if (complete && e_xcnt < CNT_MAX) e_xcnt++;
         if (any && e_ecnt < CNT_MAX) e_ecnt++;
      end
      m_stall = (m_pend && !hready) ? m_stall + 1 : 0;
      if (hready) begin
         m_pend = accept;
         if (accept) begin
            m_pend_addr = haddr; m_pend_write = hwrite; m_pend_size = hsize;
         end
         if (htrans == IDLE) m_in_burst = 0;
         else if (htrans == NONSEQ) begin
            m_in_burst = (hburst != 0);
            m_b_burst = hburst; m_b_addr = haddr; m_b_size = hsize;
         end else if (htrans == SEQ && m_in_burst) m_b_addr = haddr;
      end
      p_ready = hready; p_trans = htrans; p_addr = haddr;
      p_write = hwrite; p_size = hsize; p_resp = hresp;
   endtask

   task automatic compare_all();
      check_val("xfer_valid", xfer_valid, e_xv);
      check_val("xfer_addr", xfer_addr, e_addr);
      check_val("xfer_write", xfer_write, e_write);
      check_val("xfer_size", xfer_size, e_size);
      check_val("xfer_data", xfer_data, e_data);
      check_val("xfer_resp", xfer_resp, e_resp);
      check_val("err_valid", err_valid, e_ev);
      check_val("err_code", err_code, e_code);
      check_val("xfer_cnt", xfer_cnt, e_xcnt);
      check_val("err_cnt", err_cnt, e_ecnt);
      if (xfer_valid)
         $display("[TB] xfer addr=0x%08h %s size=%0d data=0x%08h resp=%0d cnt=%0d",
                  xfer_addr, xfer_write ? "W" : "R", xfer_size, xfer_data, xfer_resp, xfer_cnt);
   endtask

   // Inputs are already set (away from the rising edge); run one clock and check.
   task automatic cycle();
      model_step();
      @(negedge hclk);
      compare_all();
   endtask

   task automatic bus(input logic [1:0] tr, input logic [AW-1:0] a, input logic [2:0] sz,
                      input logic wr, input logic rdy, input logic [1:0] rsp,
                      input logic [2:0] bu, input logic [DW-1:0] wd, input logic [DW-1:0] rd);
      htrans = tr; haddr = a; hsize = sz; hwrite = wr; hready = rdy; hresp = rsp;
      hburst = bu; hwdata = wd; hrdata = rd;
      cycle();
   endtask

   // Random stimulus generator state: mostly legal traffic with sprinkled violations.
   int         g_beats = 0;
   int         g_stall = 0;
   logic [1:0] g_err2 = 2'd0;
   logic       g_prev_ready = 1'b1;
   logic [1:0] g_prev_resp = 2'd0;

   task automatic new_addr_phase();
      int r;
      if (g_beats > 0) begin
         if ($urandom_range(0, 9) == 0) htrans = BUSY;
         else begin
            htrans = SEQ;
            haddr  = haddr + (32'd1 << hsize);
            if ($urandom_range(0, 19) == 0) haddr = haddr + 32'd4;
            g_beats--;
         end
      end else begin
         r = $urandom_range(0, 99);
         if (r < 30) htrans = IDLE;
         else if (r < 34) htrans = SEQ;
         else begin
            htrans = NONSEQ;
            hburst = 3'($urandom_range(0, 7));
            hsize  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 4)) : 3'($urandom_range(0, 2));
            haddr  = {20'h0, 12'($urandom)} & ~((32'd1 << hsize) - 32'd1);
            if ($urandom_range(0, 19) == 0) haddr = haddr | 32'd1;
            hwrite = 1'($urandom_range(0, 1));
            case (hburst)
               3'd0:       g_beats = 0;
               3'd1:       g_beats = $urandom_range(0, 3);
               3'd2, 3'd3: g_beats = 3;
               3'd4, 3'd5: g_beats = 7;
               default:    g_beats = 15;
            endcase
         end
      end
   endtask

   task automatic gen_inputs();
      int r;
      hwdata = $urandom;
      hrdata = $urandom;
      clr    = ($urandom_range(0, 99) == 0);
      if (g_err2 != 2'd0) begin
         hready = 1'b1; hresp = g_err2; g_err2 = 2'd0;
      end else if (g_stall > 0) begin
         hready = 1'b0; hresp = 2'd0; g_stall--;
      end else begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            g_stall = $urandom_range(9, 19); hready = 1'b0; hresp = 2'd0;
         end else if (r < 18) begin
            hready = 1'b0; hresp = 2'd0;
         end else if (r < 23) begin
            hready = 1'b0; hresp = 2'($urandom_range(1, 3)); g_err2 = hresp;
         end else if (r < 25) begin
            hready = 1'b1; hresp = 2'($urandom_range(1, 3));
         end else begin
            hready = 1'b1; hresp = 2'd0;
         end
      end
      if (!g_prev_ready) begin
         if (g_prev_resp != 2'd0 && htrans == NONSEQ && $urandom_range(0, 1) == 1) begin
            htrans = IDLE; g_beats = 0;
         end else if ($urandom_range(0, 29) == 0) begin
            haddr = haddr ^ 32'h4;
         end
      end else begin
         new_addr_phase();
      end
      g_prev_ready = hready;
      g_prev_resp  = hresp;
   endtask

   initial begin
      hresetn = 1'b0; clr = 1'b0;
      htrans = IDLE; haddr = '0; hsize = 3'd0; hwrite = 1'b0; hburst = 3'd0;
      hwdata = '0; hrdata = '0; hready = 1'b1; hresp = 2'd0;
      model_reset();
      @(negedge hclk);
      cycle();
      cycle();
      hresetn = 1'b1;

      // Single write with zero waits.
      bus(NONSEQ, 32'h100, 3'd2, 1'b1, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);
      bus(IDLE,   32'h100, 3'd2, 1'b1, 1'b1, 2'd0, 3'd0, 32'hDEADBEEF, 32'h0);
      bus(IDLE,   32'h100, 3'd2, 1'b1, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);

      // INCR4 read, two waits on beat 3, then a repeat with a wrong beat-3 address.
      for (int rep = 0; rep < 2; rep++) begin
         bus(NONSEQ, 32'h200, 3'd2, 1'b0, 1'b1, 2'd0, 3'd3, 32'h0, 32'h0);
         bus(SEQ,    32'h204, 3'd2, 1'b0, 1'b1, 2'd0, 3'd3, 32'h0, 32'hA0);
         bus(SEQ,    (rep == 0) ? 32'h208 : 32'h20C, 3'd2, 1'b0, 1'b1, 2'd0, 3'd3, 32'h0, 32'hA1);
         bus(SEQ,    32'h20C, 3'd2, 1'b0, 1'b0, 2'd0, 3'd3, 32'h0, 32'h0);
         bus(SEQ,    32'h20C, 3'd2, 1'b0, 1'b0, 2'd0, 3'd3, 32'h0, 32'h0);
         bus(SEQ,    32'h20C, 3'd2, 1'b0, 1'b1, 2'd0, 3'd3, 32'h0, 32'hA2);
         bus(IDLE,   32'h0,   3'd0, 1'b0, 1'b1, 2'd0, 3'd0, 32'h0, 32'hA3);
         bus(IDLE,   32'h0,   3'd0, 1'b0, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);
      end

      // Two-cycle ERROR, then a one-cycle ERROR.
      bus(NONSEQ, 32'h300, 3'd2, 1'b0, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);
      bus(IDLE,   32'h0,   3'd0, 1'b0, 1'b0, 2'd1, 3'd0, 32'h0, 32'h0);
      bus(IDLE,   32'h0,   3'd0, 1'b0, 1'b1, 2'd1, 3'd0, 32'h0, 32'h0);
      bus(NONSEQ, 32'h304, 3'd2, 1'b0, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);
      bus(IDLE,   32'h0,   3'd0, 1'b0, 1'b1, 2'd1, 3'd0, 32'h0, 32'h0);
      bus(IDLE,   32'h0,   3'd0, 1'b0, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);

      // Long stall with an address change part way through.
      bus(NONSEQ, 32'h400, 3'd2, 1'b1, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);
      bus(NONSEQ, 32'h404, 3'd2, 1'b1, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
      for (int i = 0; i < MW + 2; i++)
         bus(NONSEQ, (i == 5) ? 32'h408 : 32'h404, 3'd2, 1'b1, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
      bus(NONSEQ, 32'h408, 3'd2, 1'b1, 1'b1, 2'd0, 3'd0, 32'h11, 32'h0);
      bus(IDLE,   32'h0,   3'd0, 1'b0, 1'b1, 2'd0, 3'd0, 32'h22, 32'h0);

      // Misaligned SEQ outside any burst: several violations in one cycle.
      bus(SEQ,    32'h102, 3'd2, 1'b0, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);
      bus(IDLE,   32'h0,   3'd0, 1'b0, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);

      // Counter saturation, clear on a completing cycle, reset mid data phase.
      for (int i = 0; i < 20; i++)
         bus(NONSEQ, 32'h500 + 32'(i * 4), 3'd2, 1'b1, 1'b1, 2'd0, 3'd0, 32'(i), 32'h0);
      clr = 1'b1;
      bus(IDLE, 32'h0, 3'd0, 1'b0, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);
      clr = 1'b0;
      bus(IDLE,   32'h0,   3'd0, 1'b0, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);
      bus(NONSEQ, 32'h600, 3'd2, 1'b1, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);
      bus(IDLE,   32'h0,   3'd0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
      hresetn = 1'b0;
      bus(IDLE,   32'h0,   3'd0, 1'b0, 1'b0, 2'd0, 3'd0, 32'h0, 32'h0);
      hresetn = 1'b1;
      bus(IDLE,   32'h0,   3'd0, 1'b0, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);
      bus(IDLE,   32'h0,   3'd0, 1'b0, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);

      // Randomized traffic.
      g_prev_ready = 1'b1;
      for (int n = 0; n < 2500; n++) begin
         gen_inputs();
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
